// File: rtl/serial_pkg.sv
// ============================================================================
// Module      : serial_pkg
// Description : Types and constants shared by the serial datapath stages.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } coll_state_t;

    localparam int SER_WORD_W = 4;

endpackage

`default_nettype wire

// File: rtl/word_hold_reg.sv
// ============================================================================
// Module      : word_hold_reg
// Description : Output word register with valid/ready handshake and sticky
//               overrun flag for words that arrive while the register is full.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module word_hold_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             out_ready_i,
    input  logic             clr_ovr_i,
    output logic [WIDTH-1:0] word_o,
    output logic             word_valid_o,
    output logic             overrun_o
);

    logic [WIDTH-1:0] word_q, word_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             w_free;

    // A draining consumer frees the register in the same cycle it is refilled.
    assign w_free = !valid_q || out_ready_i;

    always_comb begin
        word_d  = word_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (out_ready_i) begin
            valid_d = 1'b0;
        end
        if (clr_ovr_i) begin
            ovr_d = 1'b0;
        end
        if (load_i) begin
            if (w_free) begin
                word_d  = din_i;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            word_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            word_q  <= word_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = valid_q;
    assign overrun_o    = ovr_q;

endmodule

`default_nettype wire

// File: rtl/serial_word_collector.sv
// ============================================================================
// Module      : serial_word_collector
// Description : Reassembles an LSB-first serial stream into parallel words.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_word_collector
    import serial_pkg::*;
#(
    parameter int WIDTH = SER_WORD_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             bit_en,
    input  logic             sin,
    input  logic             out_ready,
    input  logic             clr_ovr,
    output logic [WIDTH-1:0] word,
    output logic             word_valid,
    output logic             busy,
    output logic             overrun
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    coll_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] w_shifted;
    logic             w_complete;

    assign w_shifted = {sin, shreg_q[WIDTH-1:1]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        w_complete = 1'b0;
        // start overrides any bit_en in the same cycle and discards a partial frame
        if (start) begin
            state_d = COLLECT;
            cnt_d   = '0;
            shreg_d = '0;
        end else if (state_q == COLLECT && bit_en) begin
            shreg_d = w_shifted;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == C_LAST) begin
                state_d    = IDLE;
                w_complete = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    assign busy = (state_q == COLLECT);

    word_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk          (clk),
        .rstn         (rstn),
        .load_i       (w_complete),
        .din_i        (w_shifted),
        .out_ready_i  (out_ready),
        .clr_ovr_i    (clr_ovr),
        .word_o       (word),
        .word_valid_o (word_valid),
        .overrun_o    (overrun)
    );

endmodule

`default_nettype wire

// File: tb/tb_serial_word_collector.sv
// ============================================================================
// Module      : tb_serial_word_collector
// Description : Scoreboard bench for serial_word_collector (WIDTH = 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_word_collector;

    localparam int W = 4;

    logic         clk;
    logic         rstn;
    logic         start;
    logic         bit_en;
    logic         sin;
    logic         out_ready;
    logic         clr_ovr;
    logic [W-1:0] word;
    logic         word_valid;
    logic         busy;
    logic         overrun;

    int           n_checks;
    int           n_errors;
    logic         ready_dflt;
    logic [W-1:0] exp_q[$];

    serial_word_collector #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .bit_en     (bit_en),
        .sin        (sin),
        .out_ready  (out_ready),
        .clr_ovr    (clr_ovr),
        .word       (word),
        .word_valid (word_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Upstream complementer output for input value i
    function automatic logic [W-1:0] twos(input logic [W-1:0] i);
        return ~i + 1'b1;
    endfunction

    task automatic pop_check(input string tag);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(word), 32'hFFFF_FFFF);
        end else begin
            check(tag, 32'(word), 32'(exp_q.pop_front()));
        end
    endtask

    // Full frame: start cycle, then W bits LSB first with an optional gap.
    task automatic send_frame(input logic [W-1:0] val, input int gap_at, input int ngap,
                              input logic rdy_last, input logic clr_last);
        start = 1'b1;
        bit_en = 1'b1;
        sin = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            bit_en = 1'b1;
            sin = val[i];
            if (i == W - 1) begin
                out_ready = rdy_last;
                clr_ovr   = clr_last;
            end
            tick();
            bit_en    = 1'b0;
            out_ready = ready_dflt;
            clr_ovr   = 1'b0;
            if (i < W - 1) check("busy_mid", 32'(busy), 32'd1);
            if (i == gap_at) begin
                for (int g = 0; g < ngap; g++) begin
                    tick();
                    check("busy_gap", 32'(busy), 32'd1);
                end
            end
        end
        check("busy_done", 32'(busy), 32'd0);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = ready_dflt;
        check("drain_valid", 32'(word_valid), 32'd0);
    endtask

    initial begin
        logic [W-1:0] v;
        n_checks   = 0;
        n_errors   = 0;
        ready_dflt = 1'b0;
        rstn = 1'b0; start = 1'b0; bit_en = 1'b0; sin = 1'b0;
        out_ready = 1'b0; clr_ovr = 1'b0;
        tick(); tick();
        check("rst_word", 32'(word), 32'd0);
        check("rst_valid", 32'(word_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        rstn = 1'b1;
        tick();

        // Basic frame: I=0110 -> 1010
        v = twos(4'b0110);
        exp_q.push_back(4'b1010);
        send_frame(v, -1, 0, 1'b0, 1'b0);
        check("t1_valid", 32'(word_valid), 32'd1);
        pop_check("t1_word");
        check("t1_ovr", 32'(overrun), 32'd0);
        drain();

        // Same frame with two idle cycles between bits 2 and 3
        exp_q.push_back(4'b1010);
        send_frame(v, 1, 2, 1'b0, 1'b0);
        check("t2_valid", 32'(word_valid), 32'd1);
        pop_check("t2_word");
        drain();

        // Overrun while held, clear, then set-wins-over-clear
        exp_q.push_back(4'b1010);
        send_frame(v, -1, 0, 1'b0, 1'b0);
        pop_check("t3_first");
        send_frame(twos(4'b0001), -1, 0, 1'b0, 1'b0);
        check("t3_word_kept", 32'(word), 32'h0000_000A);
        check("t3_valid", 32'(word_valid), 32'd1);
        check("t3_ovr", 32'(overrun), 32'd1);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        check("t3_ovr_clr", 32'(overrun), 32'd0);
        send_frame(twos(4'b0010), -1, 0, 1'b0, 1'b1);
        check("t3_set_wins", 32'(overrun), 32'd1);
        check("t3_word_kept2", 32'(word), 32'h0000_000A);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        check("t3_ovr_clr2", 32'(overrun), 32'd0);

        // Drain and refill on the completion edge: I=0011 -> 1101
        exp_q.push_back(4'b1101);
        send_frame(twos(4'b0011), -1, 0, 1'b1, 1'b0);
        check("t4_valid", 32'(word_valid), 32'd1);
        pop_check("t4_word");
        check("t4_ovr", 32'(overrun), 32'd0);
        drain();

        // Restart after 2 bits discards the partial frame
        start = 1'b1; tick(); start = 1'b0;
        bit_en = 1'b1; sin = 1'b0; tick();
        sin = 1'b1; tick();
        bit_en = 1'b0;
        check("t5_valid_partial", 32'(word_valid), 32'd0);
        exp_q.push_back(4'b1111);
        send_frame(4'b1111, -1, 0, 1'b0, 1'b0);
        pop_check("t5_word");
        drain();
        bit_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            sin = k[0];
            tick();
        end
        bit_en = 1'b0;
        check("t5_idle_busy", 32'(busy), 32'd0);
        check("t5_idle_valid", 32'(word_valid), 32'd0);
        check("t5_idle_word", 32'(word), 32'h0000_000F);

        // Asynchronous reset with a held word and a partial frame
        exp_q.push_back(4'b0110);
        send_frame(4'b0110, -1, 0, 1'b0, 1'b0);
        pop_check("t6_held");
        start = 1'b1; tick(); start = 1'b0;
        bit_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sin = 1'b1;
            tick();
        end
        bit_en = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("t6_rst_word", 32'(word), 32'd0);
        check("t6_rst_valid", 32'(word_valid), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_ovr", 32'(overrun), 32'd0);
        tick();
        rstn = 1'b1;
        tick();
        check("t6_post_busy", 32'(busy), 32'd0);
        exp_q.push_back(4'b1011);
        send_frame(twos(4'b0101), -1, 0, 1'b0, 1'b0);
        pop_check("t6_word");
        drain();

        // Back-to-back random frames with a consumer that is always ready
        ready_dflt = 1'b1;
        out_ready  = 1'b1;
        for (int f = 0; f < 6; f++) begin
            v = W'($urandom_range(0, (1 << W) - 1));
            exp_q.push_back(twos(v));
            send_frame(twos(v), -1, 0, 1'b1, 1'b0);
            check("b2b_valid", 32'(word_valid), 32'd1);
            pop_check("b2b_word");
        end
        tick();
        check("b2b_drained", 32'(word_valid), 32'd0);
        check("b2b_ovr", 32'(overrun), 32'd0);
        check("sb_left", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
